// File: rtl/mem_loader_pkg.sv
// Shared types and helpers for the memory loader: FSM state encoding and
// word/byte geometry derived from the word width.
package mem_loader_pkg;

    // Loader FSM states, in the order a single word walks through them.
    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StSetup,
        StStrobe,
        StHold,
        StFinish
    } state_e;

    // Number of bytes that make up one memory word of the given width.
    function automatic int unsigned bytes_per_word(input int unsigned width);
        return width / 8;
    endfunction

    // Width of a counter indexing the byte lanes; never narrower than one bit.
    function automatic int unsigned lane_width(input int unsigned bytes);
        return (bytes > 1) ? $clog2(bytes) : 1;
    endfunction

endpackage

// File: rtl/mem_loader_byte_assembler.sv
// Packs accepted stream bytes into an M-bit word, MSB-first: the first byte
// of a word lands in the top lane, later bytes in descending lanes.
module byte_assembler
    import mem_loader_pkg::*;
#(
    parameter int unsigned M = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic [7:0]   byteIn,
    input  logic         accept,
    output logic [M-1:0] data,
    output logic         wordFull
);

    localparam int unsigned B  = bytes_per_word(M);
    localparam int unsigned LW = lane_width(B);
    localparam logic [LW-1:0] LastLane = LW'(B - 1);

    logic [LW-1:0] lane_q;
    logic [M-1:0]  data_q;

    // The B-th accept of a word completes it; the FSM reacts on the same edge.
    assign wordFull = accept && (lane_q == LastLane);
    assign data     = data_q;

    // Lane counter and word register; start clears both so no stale lane survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
            data_q <= '0;
        end else if (clear) begin
            lane_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < B; i++) begin
                if (lane_q == LW'(i)) begin
                    data_q[M-1-8*i -: 8] <= byteIn;
                end
            end
            lane_q <= wordFull ? '0 : lane_q + LW'(1);
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Byte-stream to memory write stage. Collects big-endian words from a
// valid/ready byte stream and writes them to consecutive addresses with a
// setup / strobe / hold sequence around each WE pulse.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned N = 10,
    parameter int unsigned M = 16,
    parameter int unsigned O = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] baseAddr,
    input  logic [N:0]   wordCount,
    input  logic [7:0]   byteIn,
    input  logic         byteValid,
    output logic         byteReady,
    output logic         WE,
    output logic [N-1:0] address,
    output logic [M-1:0] writeData,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] AddrLast = N'(O - 1);
    localparam logic [N:0]   CountOne = (N + 1)'(1);

    state_e       state_q;
    logic [N-1:0] addr_q;
    logic [N:0]   remaining_q;
    logic         we_q;
    logic         ready_q;
    logic         busy_q;
    logic         done_q;

    logic         start_accept;
    logic         byte_accept;
    logic         word_full;
    logic [N-1:0] addr_next;

    assign start_accept = start && (state_q == StIdle);
    assign byte_accept  = byteValid && ready_q;
    // Depth may be smaller than the address space, so wrap explicitly at O-1.
    assign addr_next    = (addr_q == AddrLast) ? '0 : addr_q + N'(1);

    assign byteReady = ready_q;
    assign WE        = we_q;
    assign address   = addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    byte_assembler #(
        .M (M)
    ) u_byte_assembler (
        .clk      (clk),
        .reset    (reset),
        .clear    (start_accept),
        .byteIn   (byteIn),
        .accept   (byte_accept),
        .data     (writeData),
        .wordFull (word_full)
    );

    // Loader FSM with all handshake and strobe outputs registered alongside the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            we_q        <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        addr_q      <= baseAddr;
                        remaining_q <= wordCount;
                        busy_q      <= 1'b1;
                        if (wordCount == '0) begin
                            state_q <= StFinish;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= StCollect;
                            ready_q <= 1'b1;
                        end
                    end
                end
                StCollect: begin
                    // Drop ready on the completing accept so no extra byte slips in.
                    if (word_full) begin
                        state_q <= StSetup;
                        ready_q <= 1'b0;
                    end
                end
                StSetup: begin
                    state_q <= StStrobe;
                    we_q    <= 1'b1;
                end
                StStrobe: begin
                    state_q <= StHold;
                    we_q    <= 1'b0;
                end
                StHold: begin
                    remaining_q <= remaining_q - CountOne;
                    addr_q      <= addr_next;
                    if (remaining_q == CountOne) begin
                        state_q <= StFinish;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= StCollect;
                        ready_q <= 1'b1;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    we_q    <= 1'b0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Upstream write stage for `memory`. Receives a byte stream over a valid/ready handshake, assembles big-endian M-bit words, and writes them into consecutive memory locations from a programmable base address. It generates the `WE`/`address`/`writeData` triple that `memory` consumes, with a clean setup–strobe–hold sequence around the `WE` rising edge.

## Interface

- `N`, 10: address width; matches `memory` N.
- `M`, 16: word width; must be a multiple of 8. `B = M/8` bytes per word.
- `O`, 1024: memory depth in words; O ≤ 2^N.

One clock; reset is asynchronous and active-high.

- `clk` input 1: system clock; all state changes on rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `start` input 1: begin a load; sampled in IDLE only.
- `baseAddr` input N: first write address; captured on accepted `start`.
- `wordCount` input N+1: number of words to write; captured on accepted `start`.
- `byteIn` input 8: stream data.
- `byteValid` input 1: `byteIn` valid.
- `byteReady` output 1: loader accepts a byte this cycle.
- `WE` output 1: to `memory` WE.
- `address` output N: to `memory` address.
- `writeData` output M: to `memory` writeData.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a load completes.

## Operation

- States: IDLE, COLLECT, SETUP, STROBE, HOLD, FINISH.
- IDLE: `start`=1 captures `baseAddr` into the address register and `wordCount` into the remaining counter. It then goes to FINISH if `wordCount`==0, else to COLLECT. `start` is ignored in every other state.
- COLLECT: `byteReady`=1. A byte transfers when `byteValid && byteReady`.
  - First byte of a word goes to `writeData[M-1:M-8]`; later bytes fill descending byte lanes (big-endian).
  - After the B-th transfer, go to SETUP.
- SETUP: `WE`=0. `address` and `writeData` are stable.
- STROBE: `WE`=1 for exactly one cycle. The memory write occurs on this rising edge.
- HOLD: `WE`=0, with `address`/`writeData` unchanged.
  - Remaining count decrements.
  - Address increments; O-1 wraps to 0.
  - If remaining becomes 0, go to FINISH, else go to COLLECT.
- FINISH: `done`=1 for one cycle, then go to IDLE.
- `byteReady`=0 outside COLLECT. Bytes offered then are not consumed; the upstream source holds them.
- After FINISH, `address` keeps the last post-increment value. `writeData` holds the last word.
- Reset mid-operation: `WE` falls immediately, the partial word is discarded, and the FSM goes to IDLE. A write already strobed is not undone.

## Timing

- Reset values: `WE`=0, `address`=0, `writeData`=0, `byteReady`=0, `busy`=0, `done`=0, state IDLE.
- `start` to first `byteReady`: 1 cycle.
- Per word with `byteValid` held high: B accept cycles plus 3 (SETUP, STROBE, HOLD). For M=16 this is 5 cycles per word.
- Last accepted byte to `WE` rise: 2 cycles. `WE` is never high on two consecutive cycles.
- `address`/`writeData` change only on a byte accept (data) or at HOLD exit (address). Both are stable ≥1 cycle before and ≥1 cycle after `WE`.
- Last word's HOLD to `done`: 1 cycle. `done` to `busy`=0: same edge as the FINISH-to-IDLE transition.
- `wordCount`=0: `start` leads to `done` 1 cycle later, with no `WE` pulse.
- `wordCount` > O: writes wrap and overwrite earlier words. This is legal and not flagged.

## Structure

- Package `mem_loader_pkg`: state enum (IDLE, COLLECT, SETUP, STROBE, HOLD, FINISH) and a function computing `BYTES_PER_WORD` from M.
- Sub-module `byte_assembler`:
  - Shifts accepted bytes into an M-bit register MSB-first.
  - Maintains a byte-lane counter (0..B-1) and flags `wordFull` on the B-th accept.
  - Cleared by `reset` and by the loader's `start`.
- `mem_loader` top contains the FSM, the address register with wrap, and the remaining counter.
- Integration test instantiates `mem_loader` driving `memory` directly.

## Test plan

- **Basic load.** Reset, then `start` with baseAddr=0x010, wordCount=2, bytes 0x12,0x34,0xAB,0xCD back-to-back → mem[0x010]=0x1234, mem[0x011]=0xABCD. Exactly 2 `WE` pulses; `done` pulses 11 cycles after `start`.
- **Throttled source.** `byteValid` toggles every other cycle, wordCount=1, bytes 0xBE,0xEF → mem[base]=0xBEEF. `byteReady` is 0 during SETUP/STROBE/HOLD, and no byte is lost or duplicated.
- **Wrap-around.** baseAddr=0x3FF, wordCount=2, words 0x1111,0x2222 → mem[0x3FF]=0x1111, mem[0x000]=0x2222; final `address`=0x001.
- **Zero count and ignored start.** wordCount=0 → `done` 1 cycle after `start`, no `WE`. A `start` asserted while `busy` does not restart the load or change `address`.
- **Mid-word reset.** Assert `reset` after one byte of the second word → `WE`, `busy` and `byteReady` go low immediately. mem[base] keeps word 1 and mem[base+1] is unchanged. A subsequent load completes normally.
